// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 210;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: two flops, both forced to the idle value on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with a one-entry holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 uartRxPin,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 re,
  output logic                 frameError,
  output logic                 overrun,
  input  logic                 clearErr
);

  localparam int                HALF_BIT = CLKS_PER_BIT / 2;
  localparam int                CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]     HALF_M1  = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0]     FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 done;
  logic                 fe_set;
  logic                 ov_set;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (uartRxPin),
    .q    (rx_s)
  );

  // Receive FSM registers: state, bit-period counter, bit index, shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // Next-state logic; samples are taken mid-bit by offsetting half a bit in START.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    done      = 1'b0;
    fe_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_M1) begin
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          clk_cnt_d = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          if (rx_s) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) clk_cnt_d = '0;
  end

  assign ov_set = done & valid & ~re;

  // Holding register: a completed byte is accepted if empty or being read this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (done && (!valid || re)) begin
      data  <= shreg_q;
      valid <= 1'b1;
    end else if (!done && re && valid) begin
      valid <= 1'b0;
    end
  end

  // Sticky error flags; a set event outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frameError <= fe_set | (frameError & ~clearErr);
      overrun    <= ov_set | (overrun & ~clearErr);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a frame-level reference model.
module tb_uart_rx;

  localparam int C = 16;
  localparam int NOMINAL_LAT = 2 + C / 2 + 9 * C + 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       uartRxPin;
  logic [7:0] data;
  logic       valid;
  logic       re;
  logic       frameError;
  logic       overrun;
  logic       clearErr;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int rise_cyc  = 0;
  logic valid_prev = 1'b0;

  // Reference model of the user-visible state.
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_fe;
  logic       m_ov;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clock     (clock),
    .reset     (reset),
    .uartRxPin (uartRxPin),
    .data      (data),
    .valid     (valid),
    .re        (re),
    .frameError(frameError),
    .overrun   (overrun),
    .clearErr  (clearErr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record the edge count at which valid last went high.
  always @(negedge clock) begin
    if (valid === 1'b1 && valid_prev !== 1'b1) rise_cyc <= cyc;
    valid_prev <= valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".data"},  {24'd0, data},       {24'd0, m_data});
    check({tag, ".valid"}, {31'd0, valid},      {31'd0, m_valid});
    check({tag, ".fe"},    {31'd0, frameError}, {31'd0, m_fe});
    check({tag, ".ov"},    {31'd0, overrun},    {31'd0, m_ov});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit read_same);
    if (!stop_ok) m_fe = 1'b1;
    else if (!m_valid || read_same) begin
      m_data  = b;
      m_valid = 1'b1;
    end else m_ov = 1'b1;
  endfunction

  function automatic void model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endfunction

  // Drive one 10-bit frame; optional re pulse at edge start+re_at, optional reset at offset rst_at.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int re_at,
                            input int rst_at, output int start_cyc);
    start_cyc = cyc;
    for (int k = 0; k < 10 * C; k++) begin
      int bi;
      bi = k / C;
      if (bi == 0) uartRxPin = 1'b0;
      else if (bi <= 8) uartRxPin = b[bi-1];
      else uartRxPin = stop;
      if (re_at > 0) re = (k == re_at - 1);
      if (rst_at > 0 && k == rst_at) reset = 1'b1;
      if (rst_at > 0 && k == rst_at + 2) reset = 1'b0;
      tick(1);
    end
    if (re_at > 0) re = 1'b0;
  endtask

  task automatic read_byte();
    re = 1'b1;
    tick(1);
    re = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clearErr = 1'b1;
    tick(1);
    clearErr = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  // Wait (bounded) for a byte, check it, then consume it.
  task automatic read_expect(input logic [7:0] exp, input string tag);
    int waited;
    waited = 0;
    while (valid !== 1'b1 && waited < 40 * C) begin
      @(negedge clock);
      waited++;
    end
    check({tag, ".arrived"}, {31'd0, valid}, 32'd1);
    check({tag, ".data"}, {24'd0, data}, {24'd0, exp});
    @(posedge clock); #1;
    re = 1'b1;
    tick(1);
    re = 1'b0;
    check({tag, ".consumed"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int s, s2, lat, lat0;
    logic [7:0] rb;

    reset = 1'b1; uartRxPin = 1'b1; re = 1'b0; clearErr = 1'b0;
    model_reset();
    tick(3);
    check_state("reset");
    reset = 1'b0;
    tick(4);
    check_state("idle");

    // Clean frame, latency and read.
    send_frame(8'h55, 1'b1, 0, 0, s);
    model_frame(8'h55, 1'b1, 1'b0);
    lat0 = rise_cyc - s;
    check("lat55.in_window", {31'd0, (lat0 >= NOMINAL_LAT - 1 && lat0 <= NOMINAL_LAT + 1)}, 32'd1);
    check_state("rx55");
    read_byte();
    check_state("read55");

    // Back-to-back frames with concurrent reads.
    fork
      begin
        send_frame(8'hA3, 1'b1, 0, 0, s);
        send_frame(8'h0F, 1'b1, 0, 0, s2);
      end
      begin
        read_expect(8'hA3, "b2b0");
        read_expect(8'h0F, "b2b1");
      end
    join
    m_data = 8'h0F; m_valid = 1'b0;
    check_state("b2b");

    // Overrun: second byte dropped while first is unread.
    send_frame(8'h12, 1'b1, 0, 0, s);
    model_frame(8'h12, 1'b1, 1'b0);
    check_state("hold12");
    send_frame(8'h34, 1'b1, 0, 0, s);
    model_frame(8'h34, 1'b1, 1'b0);
    check_state("ovr34");
    pulse_clear();
    check_state("clr_ov");
    read_byte();
    check_state("read12");

    // Framing error followed by a long break.
    send_frame(8'h7E, 1'b0, 0, 0, s);
    model_frame(8'h7E, 1'b0, 1'b0);
    tick(40 * C);
    check_state("break");
    uartRxPin = 1'b1;
    tick(C);
    send_frame(8'h81, 1'b1, 0, 0, s);
    model_frame(8'h81, 1'b1, 1'b0);
    check_state("rx81");
    read_byte();
    pulse_clear();
    check_state("clr_fe");

    // Short glitch on an idle line, then a normal frame.
    uartRxPin = 1'b0;
    tick(3);
    uartRxPin = 1'b1;
    tick(2 * C);
    check_state("glitch");
    send_frame(8'h5A, 1'b1, 0, 0, s);
    model_frame(8'h5A, 1'b1, 1'b0);
    check_state("post_glitch");
    read_byte();

    // Reset at data bit 4 of 0xFF abandons the frame.
    send_frame(8'hFF, 1'b1, 0, 5 * C, s);
    model_reset();
    check_state("rst_mid");
    send_frame(8'hC5, 1'b1, 0, 0, s);
    model_frame(8'hC5, 1'b1, 1'b0);
    check_state("rxC5");
    read_byte();
    check_state("readC5");

    // Read strobe coinciding with delivery while full.
    send_frame(8'h3C, 1'b1, 0, 0, s);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_state("hold3C");
    send_frame(8'h99, 1'b1, lat0, 0, s);
    model_frame(8'h99, 1'b1, 1'b1);
    check_state("same_cycle");
    read_byte();
    check_state("read99");

    // Random bytes with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      tick($urandom_range(0, C));
      send_frame(rb, 1'b1, 0, 0, s);
      model_frame(rb, 1'b1, 1'b0);
      lat = rise_cyc - s;
      check("rand.lat", {31'd0, (lat >= NOMINAL_LAT - 1 && lat <= NOMINAL_LAT + 1)}, 32'd1);
      check_state("rand");
      read_byte();
      check_state("rand_read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
